// File: rtl/bitonic_feed_ctrl_pkg.sv
// Shared types for the bitonic sort feed path: pair format, pad value and
// the feed controller state encoding.
package aoc5_pkg;
  localparam int PAIR_W    = 32;
  localparam int BLK_PAIRS = 16;

  typedef struct packed {
    logic [15:0] key;
    logic [15:0] val;
  } tuple_pair_t;

  // All-ones sorts last, so pads always land above the real pairs.
  localparam logic [PAIR_W-1:0] PAD = '1;

  typedef enum logic [1:0] {FILL, WAIT, ISSUE0, ISSUE1} ctrl_state_t;
endpackage

// File: rtl/bitonic_feed_ctrl_buf.sv
// Sorted-block result buffer with the tag FIFO that pairs each sorter
// result with its {count, last} side-band; drains one pair per handshake.
module sort_result_buf
  import aoc5_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tag_push,
  input  logic [4:0]                  tag_cnt,
  input  logic                        tag_last,
  input  logic                        res_wr,
  input  logic [BLK_PAIRS*PAIR_W-1:0] res_data,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [PAIR_W-1:0]           out_pair,
  output logic                        out_last,
  output logic                        pop,
  output logic                        wr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  typedef logic [BLK_PAIRS-1:0][PAIR_W-1:0] blk_t;

  logic [4:0]    tcnt_q  [DEPTH], tcnt_d  [DEPTH];
  logic          tlast_q [DEPTH], tlast_d [DEPTH];
  logic [4:0]    rcnt_q  [DEPTH], rcnt_d  [DEPTH];
  logic          rlast_q [DEPTH], rlast_d [DEPTH];
  blk_t          res_q   [DEPTH], res_d   [DEPTH];
  logic [AW-1:0] twp_q, twp_d, trp_q, trp_d, rwp_q, rwp_d, rrp_q, rrp_d;
  logic [NW-1:0] tnum_q, tnum_d, rnum_q, rnum_d;
  logic [3:0]    idx_q, idx_d;
  logic          wr_ok, at_end;
  logic [4:0]    head_cnt;

  assign wr_ok     = res_wr && (tnum_q != '0) && (rnum_q != NW'(DEPTH));
  assign wr_err    = res_wr && !wr_ok;
  assign out_valid = rnum_q != '0;
  assign head_cnt  = rcnt_q[rrp_q];
  assign at_end    = {1'b0, idx_q} == head_cnt - 5'd1;
  assign out_pair  = res_q[rrp_q][idx_q];
  assign out_last  = out_valid && rlast_q[rrp_q] && at_end;
  assign pop       = out_valid && out_ready && at_end;

  always_comb begin
    tcnt_d  = tcnt_q;
    tlast_d = tlast_q;
    rcnt_d  = rcnt_q;
    rlast_d = rlast_q;
    res_d   = res_q;
    twp_d   = twp_q;
    trp_d   = trp_q;
    rwp_d   = rwp_q;
    rrp_d   = rrp_q;
    idx_d   = idx_q;
    if (tag_push) begin
      tcnt_d[twp_q]  = tag_cnt;
      tlast_d[twp_q] = tag_last;
      twp_d          = twp_q + 1'b1;
    end
    if (wr_ok) begin
      res_d[rwp_q]   = res_data;
      rcnt_d[rwp_q]  = tcnt_q[trp_q];
      rlast_d[rwp_q] = tlast_q[trp_q];
      rwp_d          = rwp_q + 1'b1;
      trp_d          = trp_q + 1'b1;
    end
    if (pop) begin
      idx_d = '0;
      rrp_d = rrp_q + 1'b1;
    end else if (out_valid && out_ready) begin
      idx_d = idx_q + 4'd1;
    end
    tnum_d = tnum_q + NW'(tag_push) - NW'(wr_ok);
    rnum_d = rnum_q + NW'(wr_ok) - NW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      twp_q  <= '0;
      trp_q  <= '0;
      rwp_q  <= '0;
      rrp_q  <= '0;
      tnum_q <= '0;
      rnum_q <= '0;
      idx_q  <= '0;
    end else begin
      twp_q  <= twp_d;
      trp_q  <= trp_d;
      rwp_q  <= rwp_d;
      rrp_q  <= rrp_d;
      tnum_q <= tnum_d;
      rnum_q <= rnum_d;
      idx_q  <= idx_d;
    end
  end

  // Storage is qualified by the occupancy counters, so it needs no reset.
  always_ff @(posedge clock) begin
    tcnt_q  <= tcnt_d;
    tlast_q <= tlast_d;
    rcnt_q  <= rcnt_d;
    rlast_q <= rlast_d;
    res_q   <= res_d;
  end
endmodule

// File: rtl/bitonic_feed_ctrl.sv
// Packs incoming pairs into padded 16-pair blocks, issues them to the
// external bitonic sorter under result-buffer credit, and drains results.
module bitonic_feed_ctrl
  import aoc5_pkg::*;
#(
  parameter int OUT_BLOCKS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PAIR_W-1:0]           in_pair,
  input  logic                        in_last,
  output logic                        srt_valid,
  output logic [BLK_PAIRS*PAIR_W-1:0] srt_pairs,
  input  logic                        srt_done,
  input  logic [BLK_PAIRS*PAIR_W-1:0] srt_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PAIR_W-1:0]           out_pair,
  output logic                        out_last,
  output logic                        err
);
  localparam int CW = $clog2(OUT_BLOCKS) + 1;

  ctrl_state_t                        state_q, state_d;
  logic [4:0]                         count_q, count_d;
  logic [BLK_PAIRS-1:0][PAIR_W-1:0]   slot_q, slot_d;
  logic [4:0]                         tag_cnt_q, tag_cnt_d;
  logic                               tag_last_q, tag_last_d;
  logic [CW-1:0]                      credit_q, credit_d;
  logic                               err_q, err_d;
  logic                               issue1, pop, wr_err;

  assign srt_pairs = slot_q;
  assign err       = err_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    slot_d     = slot_q;
    tag_cnt_d  = tag_cnt_q;
    tag_last_d = tag_last_q;
    in_ready   = 1'b0;
    srt_valid  = 1'b0;
    issue1     = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = count_q < 5'd16;
        if (in_valid && in_ready) begin
          slot_d[count_q[3:0]] = in_pair;
          count_d              = count_q + 5'd1;
          if (count_q == 5'd15 || in_last) begin
            tag_cnt_d  = count_q + 5'd1;
            tag_last_d = in_last;
            state_d    = (credit_q != '0) ? ISSUE0 : WAIT;
          end
        end
      end
      WAIT: if (credit_q != '0) state_d = ISSUE0;
      ISSUE0: begin
        srt_valid = 1'b1;
        state_d   = ISSUE1;
      end
      ISSUE1: begin
        srt_valid = 1'b1;
        issue1    = 1'b1;
        state_d   = FILL;
        count_d   = '0;
        // Pre-pad the next block so unfilled slots never need tracking.
        slot_d    = '1;
      end
      default: state_d = FILL;
    endcase
    credit_d = credit_q - CW'(issue1) + CW'(pop);
    err_d    = err_q | wr_err | ((state_q == FILL) && in_valid && (in_pair == PAD));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL;
      count_q    <= '0;
      slot_q     <= '1;
      tag_cnt_q  <= '0;
      tag_last_q <= 1'b0;
      credit_q   <= CW'(OUT_BLOCKS);
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      slot_q     <= slot_d;
      tag_cnt_q  <= tag_cnt_d;
      tag_last_q <= tag_last_d;
      credit_q   <= credit_d;
      err_q      <= err_d;
    end
  end

  sort_result_buf #(.DEPTH(OUT_BLOCKS)) u_buf (
    .clock     (clock),
    .reset     (reset),
    .tag_push  (issue1),
    .tag_cnt   (tag_cnt_q),
    .tag_last  (tag_last_q),
    .res_wr    (srt_done),
    .res_data  (srt_result),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pair  (out_pair),
    .out_last  (out_last),
    .pop       (pop),
    .wr_err    (wr_err)
  );
endmodule

// File: tb/tb_bitonic_feed_ctrl.sv
// Bench for bitonic_feed_ctrl: behavioural sorter stand-in plus a segment
// model (chunk into 16s, sort each chunk) driving directed and random steps.
module tb_bitonic_feed_ctrl;
  import aoc5_pkg::*;
  localparam int OB  = 4;
  localparam int LAT = 3;
  typedef logic [16*PAIR_W-1:0] blk_t;

  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0, inj_done = 1'b0;
  logic [PAIR_W-1:0] in_pair = '0;
  logic in_ready, srt_valid, out_valid, out_last, err, srt_done;
  logic mdl_done = 1'b0;
  logic [PAIR_W-1:0] out_pair;
  blk_t srt_pairs, srt_result = '0;
  assign srt_done = mdl_done | inj_done;

  bitonic_feed_ctrl #(.OUT_BLOCKS(OB)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pair(in_pair), .in_last(in_last), .srt_valid(srt_valid),
    .srt_pairs(srt_pairs), .srt_done(srt_done), .srt_result(srt_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_pair(out_pair),
    .out_last(out_last), .err(err)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sorter stand-in: two identical valid beats in, sorted block out LAT cycles later.
  function automatic blk_t sort16(input blk_t b);
    logic [PAIR_W-1:0] a [16];
    logic [PAIR_W-1:0] t;
    for (int i = 0; i < 16; i++) a[i] = b[i*PAIR_W +: PAIR_W];
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 15 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 16; i++) sort16[i*PAIR_W +: PAIR_W] = a[i];
  endfunction

  blk_t pend_q[$];
  int   pend_due[$];
  blk_t cap;
  int   run_len = 0, cyc = 0, srt_bad = 0, n_issue = 0;
  always @(negedge clock) begin
    cyc++;
    mdl_done = 1'b0;
    if (reset) begin
      pend_q.delete(); pend_due.delete(); run_len = 0;
    end else begin
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mdl_done = 1'b1;
        srt_result = pend_q.pop_front();
        void'(pend_due.pop_front());
      end
      if (srt_valid) begin
        if (run_len == 0) cap = srt_pairs;
        else if (srt_pairs !== cap) srt_bad++;
        run_len++;
        if (run_len == 2) begin
          pend_q.push_back(sort16(cap)); pend_due.push_back(cyc + LAT); n_issue++;
        end
      end else begin
        if (run_len != 0 && run_len != 2) srt_bad++;
        run_len = 0;
      end
    end
  end

  logic [PAIR_W-1:0] seg[$], inq[$], expq[$];
  bit inl[$], expl[$];

  task automatic commit_seg();
    logic [PAIR_W-1:0] ch[$];
    for (int i = 0; i < seg.size(); i++) begin
      inq.push_back(seg[i]); inl.push_back(i == seg.size() - 1);
      ch.push_back(seg[i]);
      if (ch.size() == 16 || i == seg.size() - 1) begin
        ch.sort();
        foreach (ch[k]) begin
          expq.push_back(ch[k]);
          expl.push_back(i == seg.size() - 1 && k == ch.size() - 1);
        end
        ch.delete();
      end
    end
    seg.delete();
  endtask

  task automatic rand_seg(input int n);
    for (int i = 0; i < n; i++)
      seg.push_back((i % 2) ? PAIR_W'($urandom_range(0, 50)) : PAIR_W'($urandom() >> 1));
    commit_seg();
  endtask

  task automatic run(input bit en_out, input bit rnd, input int max_cyc);
    int c = 0;
    bit held = 0, hl = 0;
    logic [PAIR_W-1:0] hp = '0;
    forever begin
      @(negedge clock);
      if ((inq.size() == 0 && (!en_out || expq.size() == 0)) || c >= max_cyc) break;
      c++;
      if (held) begin
        chk("hold_valid", out_valid, 1); chk("hold_pair", out_pair, hp); chk("hold_last", out_last, hl);
      end
      in_valid = 1'b0;
      if (inq.size() > 0) begin
        in_valid = !rnd || $urandom_range(0, 3) != 0;
        in_pair = inq[0]; in_last = inl[0];
      end
      out_ready = en_out && (!rnd || $urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin void'(inq.pop_front()); void'(inl.pop_front()); end
      held = out_valid && !out_ready; hp = out_pair; hl = out_last;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("extra_out", 1, 0);
        else begin
          chk("out_pair", out_pair, expq.pop_front());
          chk("out_last", out_last, expl.pop_front());
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("run_timeout", c >= max_cyc, 0);
  endtask

  task automatic settle();
    repeat (LAT + 6) @(negedge clock);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_err", err, 0);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    inq.delete(); inl.delete(); expq.delete(); expl.delete();
    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 1); chk("rst_srt_valid", srt_valid, 0);
    chk("rst_out_valid", out_valid, 0); chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", in_ready, 1); chk("post_rst_credit", dut.credit_q, OB);
    chk("post_rst_out_valid", out_valid, 0);
  endtask

  int i0;
  initial begin
    do_reset();

    // Sixteen descending pairs, last on the 16th.
    for (int v = 16; v >= 1; v--) seg.push_back(PAIR_W'(v));
    commit_seg();
    i0 = n_issue;
    run(1, 0, 400);
    settle();
    chk("desc16_issues", n_issue - i0, 1);

    // Short segment: pads must fill the block and never come out.
    seg.push_back(9); seg.push_back(2); seg.push_back(5);
    commit_seg();
    run(1, 0, 200);
    settle();

    // Five full blocks with the consumer stalled: credit runs out on the fifth.
    i0 = n_issue;
    for (int b = 0; b < 5; b++) rand_seg(16);
    run(0, 0, 500);
    repeat (12) @(negedge clock);
    chk("stall_issues", n_issue - i0, 4);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_srt_valid", srt_valid, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_credit", dut.credit_q, 0);
    chk("stall_head", out_pair, expq[0]);
    run(1, 0, 1000);
    settle();
    chk("stall_resume_issues", n_issue - i0, 5);

    // Head block pops in the same cycle as ISSUE1.
    @(negedge clock); in_valid = 1'b1; in_pair = 7; in_last = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    repeat (LAT + 6) @(negedge clock);
    chk("coinc_head_valid", out_valid, 1); chk("coinc_head_pair", out_pair, 7);
    chk("coinc_credit_before", dut.credit_q, OB - 1);
    in_valid = 1'b1; in_pair = 3; in_last = 1'b0;
    @(negedge clock); in_pair = 1; in_last = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    chk("coinc_issue0", srt_valid, 1);
    @(negedge clock);
    chk("coinc_issue1", srt_valid, 1); chk("coinc_last", out_last, 1);
    out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
    chk("coinc_credit_after", dut.credit_q, OB - 1);
    chk("coinc_err", err, 0);
    expq.push_back(1); expl.push_back(0); expq.push_back(3); expl.push_back(1);
    run(1, 0, 200);
    settle();

    // Reset while ISSUE0 is driving with two blocks buffered.
    rand_seg(5); rand_seg(16);
    run(0, 0, 200);
    repeat (LAT + 6) @(negedge clock);
    chk("mid_buffered", out_valid, 1);
    in_valid = 1'b1; in_pair = 42; in_last = 1'b1;
    @(negedge clock); in_valid = 1'b0;
    chk("mid_issue0", srt_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_out_valid", out_valid, 0); chk("mid_rst_srt_valid", srt_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1); chk("mid_rst_credit", dut.credit_q, OB);
    @(negedge clock); reset = 1'b0;
    inq.delete(); inl.delete(); expq.delete(); expl.delete();
    settle();

    // Random segments with random handshakes on both sides.
    for (int s = 0; s < 8; s++) rand_seg($urandom_range(1, 40));
    run(1, 1, 6000);
    settle();

    // Spurious sorter completion is a sticky error.
    @(negedge clock); inj_done = 1'b1;
    @(negedge clock); inj_done = 1'b0;
    chk("spurious_err", err, 1);
    repeat (5) @(negedge clock);
    chk("spurious_err_held", err, 1);
    do_reset();

    chk("sorter_protocol", srt_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
